// File: rtl/transpose_pkg.sv
// Shared types and helpers for the chunked-transpose address generator.
package transpose_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef enum logic {MODE_TRANSPOSE, MODE_COPY} mode_t;

  function automatic int elem_bytes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/transpose_addr_gen_tile_counter.sv
// Four-level tile/element counter: elements row-major inside a tile, tiles row-major.
// Wraps to element 0 after the final element of the job.
module tile_counter #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int CHUNK_SIZE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        advance_i,
  output logic [31:0] r_o,
  output logic [31:0] c_o,
  output logic        chunk_last_o,
  output logic        last_o
);

  localparam int TR_N = ROWS / CHUNK_SIZE;
  localparam int TC_N = COLS / CHUNK_SIZE;
  localparam int CW   = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;
  localparam int TRW  = (TR_N > 1) ? $clog2(TR_N) : 1;
  localparam int TCW  = (TC_N > 1) ? $clog2(TC_N) : 1;

  localparam logic [CW-1:0]  IC_MAX = CW'(CHUNK_SIZE - 1);
  localparam logic [TRW-1:0] TR_MAX = TRW'(TR_N - 1);
  localparam logic [TCW-1:0] TC_MAX = TCW'(TC_N - 1);

  logic [TRW-1:0] tr_q, tr_d;
  logic [TCW-1:0] tc_q, tc_d;
  logic [CW-1:0]  ir_q, ir_d;
  logic [CW-1:0]  ic_q, ic_d;

  logic ic_wrap, ir_wrap, tc_wrap, tr_wrap;

  assign ic_wrap = (ic_q == IC_MAX);
  assign ir_wrap = (ir_q == IC_MAX);
  assign tc_wrap = (tc_q == TC_MAX);
  assign tr_wrap = (tr_q == TR_MAX);

  always_comb begin
    tr_d = tr_q;
    tc_d = tc_q;
    ir_d = ir_q;
    ic_d = ic_q;
    if (clear_i) begin
      tr_d = '0;
      tc_d = '0;
      ir_d = '0;
      ic_d = '0;
    end else if (advance_i) begin
      if (!ic_wrap) begin
        ic_d = ic_q + 1'b1;
      end else begin
        ic_d = '0;
        if (!ir_wrap) begin
          ir_d = ir_q + 1'b1;
        end else begin
          // Tile finished: step to the next tile in row-major tile order.
          ir_d = '0;
          if (!tc_wrap) begin
            tc_d = tc_q + 1'b1;
          end else begin
            tc_d = '0;
            tr_d = tr_wrap ? '0 : tr_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tr_q <= '0;
      tc_q <= '0;
      ir_q <= '0;
      ic_q <= '0;
    end else begin
      tr_q <= tr_d;
      tc_q <= tc_d;
      ir_q <= ir_d;
      ic_q <= ic_d;
    end
  end

  assign r_o          = 32'(tr_q) * 32'(CHUNK_SIZE) + 32'(ir_q);
  assign c_o          = 32'(tc_q) * 32'(CHUNK_SIZE) + 32'(ic_q);
  assign chunk_last_o = ic_wrap && ir_wrap;
  assign last_o       = ic_wrap && ir_wrap && tc_wrap && tr_wrap;

endmodule

// File: rtl/transpose_addr_gen.sv
// Chunked-transpose address generator: one (load, store) byte-address pair per element,
// first pair one cycle after start, pair held stable while out_ready is low.
module transpose_addr_gen
  import transpose_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int CHUNK_SIZE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  output logic                  busy,
  output logic                  done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] ld_addr,
  output logic [ADDR_WIDTH-1:0] st_addr,
  output logic                  chunk_last,
  output logic                  last
);

  localparam int EB = elem_bytes(DATA_WIDTH);
  localparam int WW = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;

  state_t                state_q, state_d;
  mode_t                 mode_q;
  logic [ADDR_WIDTH-1:0] src_q, dst_q;

  logic        launch, fire, run;
  logic [31:0] r, c;
  logic        cnt_chunk_last, cnt_last;

  assign run    = (state_q == RUN);
  assign launch = (state_q == IDLE) && start;
  assign fire   = run && out_ready;

  tile_counter #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .CHUNK_SIZE (CHUNK_SIZE)
  ) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (launch),
    .advance_i    (fire),
    .r_o          (r),
    .c_o          (c),
    .chunk_last_o (cnt_chunk_last),
    .last_o       (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (fire && cnt_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_TRANSPOSE;
      src_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        mode_q <= mode_t'(mode);
        src_q  <= src_base;
        dst_q  <= dst_base;
      end
    end
  end

  // Linear element indices are formed wide; truncation to ADDR_WIDTH is modular.
  logic [WW-1:0]         row_lin, col_lin;
  logic [ADDR_WIDTH-1:0] ld_full, st_full;

  assign row_lin = WW'(r) * WW'(COLS) + WW'(c);
  assign col_lin = WW'(c) * WW'(ROWS) + WW'(r);
  assign ld_full = src_q + ADDR_WIDTH'(row_lin * WW'(EB));
  assign st_full = dst_q + ADDR_WIDTH'(((mode_q == MODE_COPY) ? row_lin : col_lin) * WW'(EB));

  assign out_valid  = run;
  assign busy       = run;
  assign done       = (state_q == DONE);
  assign ld_addr    = run ? ld_full : '0;
  assign st_addr    = run ? st_full : '0;
  assign chunk_last = run && cnt_chunk_last;
  assign last       = run && cnt_last;

endmodule

// File: tb/tb_transpose_addr_gen.sv
// Scoreboard bench: stimulus pushes expected address pairs, a negedge monitor pops and compares.
module tb_transpose_addr_gen;

  typedef struct packed {
    logic [7:0] ld;
    logic [7:0] st;
    logic       cl;
    logic       lst;
  } pair_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_start, a_mode, a_busy, a_done, a_valid, a_ready, a_cl, a_last;
  logic [7:0] a_src, a_dst, a_ld, a_st;
  logic       b_start, b_mode, b_busy, b_done, b_valid, b_ready, b_cl, b_last;
  logic [7:0] b_src, b_dst, b_ld, b_st;

  transpose_addr_gen #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .ROWS(8), .COLS(8), .CHUNK_SIZE(2)) u_dut (
    .clk(clk), .rst(rst), .start(a_start), .mode(a_mode), .src_base(a_src), .dst_base(a_dst),
    .busy(a_busy), .done(a_done), .out_valid(a_valid), .out_ready(a_ready),
    .ld_addr(a_ld), .st_addr(a_st), .chunk_last(a_cl), .last(a_last)
  );

  transpose_addr_gen #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .ROWS(4), .COLS(8), .CHUNK_SIZE(2)) u_rect (
    .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .src_base(b_src), .dst_base(b_dst),
    .busy(b_busy), .done(b_done), .out_valid(b_valid), .out_ready(b_ready),
    .ld_addr(b_ld), .st_addr(b_st), .chunk_last(b_cl), .last(b_last)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  pair_t q_a[$];
  pair_t q_b[$];

  int cyc = 0, a_tot = 0, b_tot = 0;
  int a_busy_tot = 0, a_done_tot = 0, a_done_cyc = 0, a_last_cyc = 0;
  logic [7:0] a_ld_log[0:511], a_st_log[0:511];
  logic       a_cl_log[0:511], a_last_log[0:511];
  logic [7:0] b_ld_log[0:63], b_st_log[0:63];
  logic       b_last_log[0:63];
  pair_t mon_got, mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_model(input bit to_b, input int rows, input int cols, input int ch,
                            input bit copy, input int src, input int dst);
    pair_t p;
    int r, c;
    for (int tr = 0; tr < rows / ch; tr++)
      for (int tc = 0; tc < cols / ch; tc++)
        for (int ir = 0; ir < ch; ir++)
          for (int ic = 0; ic < ch; ic++) begin
            r     = tr * ch + ir;
            c     = tc * ch + ic;
            p.ld  = 8'(src + (r * cols + c) * 4);
            p.st  = copy ? 8'(dst + (r * cols + c) * 4) : 8'(dst + (c * rows + r) * 4);
            p.cl  = (ir == ch - 1) && (ic == ch - 1);
            p.lst = p.cl && (tr == rows / ch - 1) && (tc == cols / ch - 1);
            if (to_b) q_b.push_back(p);
            else      q_a.push_back(p);
          end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (a_busy) a_busy_tot++;
      if (a_done) begin
        a_done_tot++;
        a_done_cyc = cyc;
      end
      if (a_valid && a_ready) begin
        mon_got = {a_ld, a_st, a_cl, a_last};
        if (q_a.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL a_unexpected_pair: got 0x%0h, expected no transfer", mon_got);
        end else begin
          mon_exp = q_a.pop_front();
          check("a_pair", 32'(mon_got), 32'(mon_exp));
        end
        if (a_tot < 512) begin
          a_ld_log[a_tot]   = a_ld;
          a_st_log[a_tot]   = a_st;
          a_cl_log[a_tot]   = a_cl;
          a_last_log[a_tot] = a_last;
        end
        if (a_last) a_last_cyc = cyc;
        a_tot++;
      end
      if (b_valid && b_ready) begin
        mon_got = {b_ld, b_st, b_cl, b_last};
        if (q_b.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL b_unexpected_pair: got 0x%0h, expected no transfer", mon_got);
        end else begin
          mon_exp = q_b.pop_front();
          check("b_pair", 32'(mon_got), 32'(mon_exp));
        end
        if (b_tot < 64) begin
          b_ld_log[b_tot]   = b_ld;
          b_st_log[b_tot]   = b_st;
          b_last_log[b_tot] = b_last;
        end
        b_tot++;
      end
    end
  end

  task automatic start_a(input logic m, input logic [7:0] src, input logic [7:0] dst);
    a_mode  = m;
    a_src   = src;
    a_dst   = dst;
    a_start = 1'b1;
    @(posedge clk);
    #1 a_start = 1'b0;
  endtask

  task automatic wait_a_done();
    int k = 0;
    while (a_done !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("a_done_seen", 32'(a_done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_b_done();
    int k = 0;
    while (b_done !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("b_done_seen", 32'(b_done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string name, input int idx, input logic [7:0] ld, input logic [7:0] st);
    check(name, 32'({a_ld_log[idx], a_st_log[idx]}), 32'({ld, st}));
  endtask

  task automatic chk_b(input string name, input int idx, input logic [7:0] ld, input logic [7:0] st);
    check(name, 32'({b_ld_log[idx], b_st_log[idx]}), 32'({ld, st}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, busy0, done0, k;
    rst = 1'b1;
    a_start = 0; a_mode = 0; a_src = 0; a_dst = 0; a_ready = 1;
    b_start = 0; b_mode = 0; b_src = 0; b_dst = 0; b_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state_a", 32'({a_valid, a_busy, a_done, a_ld, a_st, a_cl, a_last}), 32'd0);
    check("reset_state_b", 32'({b_valid, b_busy, b_done, b_ld, b_st, b_cl, b_last}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Job 1: 8x8 transpose, no backpressure, start pulsed mid-run with other bases.
    base = a_tot; busy0 = a_busy_tot; done0 = a_done_tot;
    push_model(0, 8, 8, 2, 0, 0, 0);
    start_a(0, 8'h00, 8'h00);
    repeat (5) @(posedge clk);
    #1 begin a_start = 1; a_mode = 1; a_src = 8'h40; a_dst = 8'h40; end
    @(posedge clk);
    #1 begin a_start = 0; a_mode = 0; a_src = 0; a_dst = 0; end
    wait_a_done();
    chk_a("j1_pair1", base + 0, 8'd0, 8'd0);
    chk_a("j1_pair2", base + 1, 8'd4, 8'd32);
    chk_a("j1_pair3", base + 2, 8'd32, 8'd4);
    chk_a("j1_pair4", base + 3, 8'd36, 8'd36);
    chk_a("j1_pair5", base + 4, 8'd8, 8'd64);
    check("j1_chunk_last_p3", 32'(a_cl_log[base + 2]), 32'd0);
    check("j1_chunk_last_p4", 32'(a_cl_log[base + 3]), 32'd1);
    chk_a("j1_pair64", base + 63, 8'd252, 8'd252);
    check("j1_last_p64", 32'(a_last_log[base + 63]), 32'd1);
    check("j1_transfers", 32'(a_tot - base), 32'd64);
    check("j1_busy_cycles", 32'(a_busy_tot - busy0), 32'd64);
    check("j1_done_pulses", 32'(a_done_tot - done0), 32'd1);
    check("j1_done_timing", 32'(a_done_cyc - a_last_cyc), 32'd1);

    // Job 2: stall three cycles on the second pair.
    base = a_tot;
    push_model(0, 8, 8, 2, 0, 0, 0);
    start_a(0, 8'h00, 8'h00);
    @(posedge clk);
    #1 a_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("j2_stall_hold", 32'({a_valid, a_ld, a_st}), 32'({1'b1, 8'd4, 8'd32}));
      @(posedge clk);
    end
    #1 a_ready = 1'b1;
    wait_a_done();
    chk_a("j2_pair2", base + 1, 8'd4, 8'd32);
    check("j2_transfers", 32'(a_tot - base), 32'd64);

    // Job 3: copy mode into dst 128.
    base = a_tot;
    push_model(0, 8, 8, 2, 1, 0, 128);
    start_a(1, 8'h00, 8'h80);
    wait_a_done();
    chk_a("j3_copy_pair2", base + 1, 8'd4, 8'd132);
    check("j3_transfers", 32'(a_tot - base), 32'd64);

    // Job 4: address wrap from src_base 0xF0.
    base = a_tot;
    push_model(0, 8, 8, 2, 0, 32'hF0, 0);
    start_a(0, 8'hF0, 8'h00);
    wait_a_done();
    check("j4_wrap_ld_p3", 32'(a_ld_log[base + 2]), 32'h10);

    // Job 5: reset at the 10th transfer, then restart.
    base = a_tot;
    push_model(0, 8, 8, 2, 0, 0, 0);
    start_a(0, 8'h00, 8'h00);
    k = 0;
    while (a_tot < base + 10 && k < 500) begin
      @(posedge clk);
      k++;
    end
    check("j5_reached_10", 32'(a_tot - base), 32'd10);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("j5_after_rst", 32'({a_valid, a_busy, a_done}), 32'd0);
    q_a.delete();
    done0 = a_done_tot;
    repeat (3) @(posedge clk);
    #1 check("j5_no_done", 32'(a_done_tot - done0), 32'd0);
    base = a_tot;
    push_model(0, 8, 8, 2, 0, 0, 0);
    start_a(0, 8'h00, 8'h00);
    wait_a_done();
    chk_a("j5_restart_pair1", base + 0, 8'd0, 8'd0);
    check("j5_transfers", 32'(a_tot - base), 32'd64);

    // Rectangular 4x8 transpose.
    base = b_tot;
    push_model(1, 4, 8, 2, 0, 0, 0);
    b_start = 1'b1;
    @(posedge clk);
    #1 b_start = 1'b0;
    wait_b_done();
    chk_b("rect_pair2", base + 1, 8'd4, 8'd16);
    chk_b("rect_pair3", base + 2, 8'd32, 8'd4);
    chk_b("rect_pair32", base + 31, 8'd124, 8'd124);
    check("rect_last", 32'(b_last_log[base + 31]), 32'd1);
    check("rect_transfers", 32'(b_tot - base), 32'd32);

    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
